// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the
// sequential multiply/divide unit.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_COUNT = 32;
  localparam logic [4:0] CNT_INIT =
    5'(ITER_COUNT - 1);

  function automatic logic [31:0] abs32(
    input logic [31:0] v
  );
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_iter_core.sv
// Iteration datapath: 64-bit accumulator
// with shift-add and restoring divide step.
module muldiv_iter_core
  import muldiv_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        op,
  input  logic [31:0] lo_init,
  input  logic [31:0] opnd,
  output logic [63:0] acc
);

  logic [31:0] opnd_q;
  logic [63:0] acc_nx;
  logic [63:0] sh;
  logic [32:0] sum;
  logic [32:0] diff;

  // One iteration: mult adds into the top
  // half and shifts right; div shifts left
  // and keeps the trial subtract if >= 0.
  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, opnd_q};
    sh   = {acc[62:0], 1'b0};
    diff = {1'b0, sh[63:32]} - {1'b0, opnd_q};
    if (op == OP_MULT) begin
      acc_nx = acc[0] ? {sum, acc[31:1]}
                      : {1'b0, acc[63:1]};
    end else begin
      acc_nx = diff[32] ? sh
             : {diff[31:0], sh[31:0] | 32'd1};
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd_q <= '0;
    end else if (load) begin
      acc    <= {32'd0, lo_init};
      opnd_q <= opnd;
    end else if (step) begin
      acc    <= acc_nx;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Signed 32x32 mult / 32/32 div sequencer.
// MULDIV_DIVZERO_EXC_EN: div-by-zero trap.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        hilo_write,
`ifdef MULDIV_DIVZERO_EXC_EN
  output logic        div_zero,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  state_t      state_nx;
  logic        op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        sign_a_q;
  logic        bz_q;
  logic        load;
  logic        step;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] acc;
  logic [63:0] res;
`ifdef MULDIV_DIVZERO_EXC_EN
  logic        dz_set;
`endif

  assign abs_a = abs32(a_q);
  assign abs_b = abs32(b_q);

  muldiv_iter_core u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .op      (op_q),
    .lo_init (op_q == OP_MULT ? abs_b : abs_a),
    .opnd    (op_q == OP_MULT ? abs_a : abs_b),
    .acc     (acc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and Moore outputs.
  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    done       = 1'b0;
    hilo_write = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
    dz_set     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = INIT;
      end
      INIT: begin
        load     = 1'b1;
        state_nx = RUN;
`ifdef MULDIV_DIVZERO_EXC_EN
        if (op_q == OP_DIV && b_q == '0) begin
          load     = 1'b0;
          dz_set   = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      RUN: begin
        step = 1'b1;
        if (cnt == '0) state_nx = FIX;
      end
      FIX: state_nx = DONE;
      DONE: begin
        done       = 1'b1;
        hilo_write = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are latched only on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state == IDLE && start) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Result signs and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      bz_q     <= 1'b0;
    end else if (state == INIT) begin
      cnt      <= CNT_INIT;
      neg_q    <= a_q[31] ^ b_q[31];
      sign_a_q <= a_q[31];
      bz_q     <= (b_q == '0);
    end else if (state == RUN) begin
      cnt      <= cnt - 5'd1;
    end
  end

  // Sign correction; a zero divisor yields
  // an all-ones quotient and remainder = a.
  always_comb begin
    res = acc;
    if (op_q == OP_MULT) begin
      if (neg_q) res = -acc;
    end else if (bz_q) begin
      res = {a_q, 32'hFFFF_FFFF};
    end else begin
      res[31:0]  = neg_q ? -acc[31:0]
                         : acc[31:0];
      res[63:32] = sign_a_q ? -acc[63:32]
                            : acc[63:32];
    end
  end

  // HI/LO take the result as DONE is entered,
  // so they are valid in the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= res[63:32];
      lo <= res[31:0];
    end
  end

`ifdef MULDIV_DIVZERO_EXC_EN
  // One-cycle trap pulse after INIT aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_zero <= 1'b0;
    else       div_zero <= dz_set;
  end
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer
// against a plain-arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic        hilo_write;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULDIV_DIVZERO_EXC_EN
  logic        div_zero;
`endif

  muldiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hilo_write (hilo_write),
`ifdef MULDIV_DIVZERO_EXC_EN
    .div_zero   (div_zero),
`endif
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input logic o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint p;
    longint q;
    longint r;
    if (o == 1'b0) begin
      p = sx * sy;
      return p;
    end
    if (y == 0) return {x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done.
  always @(negedge clk) begin
    if (!reset) begin
      chk("hilo_write_eq_done",
          64'(hilo_write), 64'(done));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          chk({e.name, "_latency"},
              64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic issue(input logic o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input string nm,
                       output int n);
    exp_t e;
    logic [63:0] m;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 1'($urandom);
    n     = cyc;
    chk({nm, "_busy_c1"}, 64'(busy), 64'(1));
    m = model(o, x, y);
`ifdef MULDIV_DIVZERO_EXC_EN
    if (o && y == 0) return;
`endif
    e.hi   = m[63:32];
    e.lo   = m[31:0];
    e.due  = n + 34;
    e.name = nm;
    sb.push_back(e);
    last_res = m;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (k >= 80) begin
      chk({nm, "_timeout"}, 64'(1), 64'(0));
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic o;
    logic [31:0] x;
    logic [31:0] y;
    reset = 1'b1;
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hw", 64'(hilo_write), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
`ifdef MULDIV_DIVZERO_EXC_EN
    chk("rst_dz", 64'(div_zero), 64'(0));
`endif
    @(posedge clk);
    #1 reset = 1'b0;

    issue(1'b0, 32'd6, 32'hFFFF_FFF9, "mul_6_m7", n);
    wait_done("mul_6_m7");

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", n);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      chk($sformatf("div_busy_c%0d", k),
          64'(busy), 64'(k <= 35));
    end
    wait_done("div_m7_2");
    repeat (3) @(negedge clk);
    chk("hold_hi", 64'(hi), 64'(last_res[63:32]));
    chk("hold_lo", 64'(lo), 64'(last_res[31:0]));

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          "div_ovf", n);
    wait_done("div_ovf");

    issue(1'b1, 32'd100, 32'd0, "div_zero", n);
`ifdef MULDIV_DIVZERO_EXC_EN
    @(negedge clk);
    chk("dz_c1", 64'(div_zero), 64'(0));
    @(negedge clk);
    chk("dz_c2", 64'(div_zero), 64'(1));
    chk("dz_c2_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("dz_c3", 64'(div_zero), 64'(0));
    repeat (40) @(negedge clk);
    chk("dz_hi", 64'(hi), 64'(last_res[63:32]));
    chk("dz_lo", 64'(lo), 64'(last_res[31:0]));
`else
    wait_done("div_zero");
`endif

    issue(1'b0, 32'd3, 32'd4, "mul_3_4", n);
    do @(negedge clk); while (cyc != n + 9);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    do @(negedge clk); while (cyc != n + 34);
    chk("ign_done_cycle", 64'(done), 64'(1));
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_after_done", 64'(busy), 64'(0));
    issue(1'b0, 32'd9, 32'hFFFF_FFFE, "mul_9_m2", n);
    wait_done("mul_9_m2");

    issue(1'b0, 32'd5, 32'd5, "mul_5_5", n);
    do @(negedge clk); while (cyc != n + 20);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    issue(1'b0, 32'd7, 32'd7, "mul_7_7", n);
    wait_done("mul_7_7");

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      x = pick();
      y = pick();
`ifdef MULDIV_DIVZERO_EXC_EN
      if (o && y == 0) y = 32'd3;
`endif
      issue(o, x, y, $sformatf("rnd%0d", i), n);
      wait_done($sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge clk);
    chk("end_hi", 64'(hi), 64'(last_res[63:32]));
    chk("end_lo", 64'(lo), 64'(last_res[31:0]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
